// File: rtl/wb_write_buffer.sv
// Register write-back buffer: 4-entry FIFO fed by the EX and MEM stages,
// drained one entry per cycle into a registered register-file write port,
// with four combinational forwarding lookups into the pending writes.
// Build option: define WB_FORWARD_EN to include the forwarding logic;
// without it every fwdN_hit/fwdN_data output is tied to zero.
module wb_write_buffer (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ex_valid,
  input  logic [3:0]  ex_addr,
  input  logic [31:0] ex_data,
  input  logic        mem_valid,
  input  logic [3:0]  mem_addr,
  input  logic [31:0] mem_data,
  input  logic        freeze,
  input  logic [3:0]  src1_add,
  input  logic [3:0]  src2_add,
  input  logic [3:0]  src3_add,
  input  logic [3:0]  dest_add,
  output logic        fwd1_hit,
  output logic [31:0] fwd1_data,
  output logic        fwd2_hit,
  output logic [31:0] fwd2_data,
  output logic        fwd3_hit,
  output logic [31:0] fwd3_data,
  output logic        fwd4_hit,
  output logic [31:0] fwd4_data,
  output logic        write,
  output logic [3:0]  write_back_address,
  output logic [31:0] data_write,
  output logic        stall,
  output logic        overflow,
  output logic [2:0]  count
);

  logic [3:0]  fifo_addr_q [4];
  logic [3:0]  fifo_addr_d [4];
  logic [31:0] fifo_data_q [4];
  logic [31:0] fifo_data_d [4];
  logic [1:0]  head_q, head_d, tail_q, tail_d;
  logic [2:0]  count_q, count_d;
  logic        write_q, write_d;
  logic [3:0]  wb_addr_q, wb_addr_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        overflow_q, overflow_d;

  logic        pop, mem_acc, ex_acc;
  logic [2:0]  free_slots;
  logic [1:0]  ex_slot;

  // Admission (MEM first, EX only if a second slot is free), drain and next state
  always_comb begin
    pop        = (count_q != 3'd0) && !freeze;
    // A pop releases its slot on the same edge, so it counts as free space.
    free_slots = 3'd4 - count_q + {2'b00, pop};
    mem_acc    = mem_valid && (free_slots != 3'd0);
    ex_acc     = ex_valid && (free_slots > {2'b00, mem_acc});
    ex_slot    = mem_acc ? (tail_q + 2'd1) : tail_q;

    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    if (mem_acc) begin
      fifo_addr_d[tail_q] = mem_addr;
      fifo_data_d[tail_q] = mem_data;
    end
    if (ex_acc) begin
      fifo_addr_d[ex_slot] = ex_addr;
      fifo_data_d[ex_slot] = ex_data;
    end

    tail_d     = tail_q + {1'b0, mem_acc} + {1'b0, ex_acc};
    head_d     = head_q + {1'b0, pop};
    count_d    = count_q + {2'b00, mem_acc} + {2'b00, ex_acc} - {2'b00, pop};
    overflow_d = overflow_q | (mem_valid && !mem_acc) | (ex_valid && !ex_acc);

    write_d   = pop;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    if (pop) begin
      wb_addr_d = fifo_addr_q[head_q];
      wb_data_d = fifo_data_q[head_q];
    end
  end

  // State registers; reset drops queued entries and pending requests
  always_ff @(posedge clock) begin
    fifo_addr_q <= fifo_addr_d;
    fifo_data_q <= fifo_data_d;
    if (!reset_n) begin
      head_q     <= 2'd0;
      tail_q     <= 2'd0;
      count_q    <= 3'd0;
      write_q    <= 1'b0;
      wb_addr_q  <= 4'd0;
      wb_data_q  <= 32'd0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      write_q    <= write_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef WB_FORWARD_EN
  logic [3:0]  look_add [4];
  logic [3:0]  fwd_hit;
  logic [31:0] fwd_data [4];

  // Youngest-to-oldest search of queued entries, then the write-back register
  always_comb begin
    logic       found;
    logic [1:0] slot;
    look_add[0] = src1_add;
    look_add[1] = src2_add;
    look_add[2] = src3_add;
    look_add[3] = dest_add;
    fwd_hit     = 4'd0;
    for (int p = 0; p < 4; p++) begin
      fwd_data[p] = 32'd0;
      found       = 1'b0;
      for (int i = 0; i < 4; i++) begin
        slot = tail_q - 2'(i) - 2'd1;
        if (!found && (3'(i) < count_q) && (fifo_addr_q[slot] == look_add[p])) begin
          found       = 1'b1;
          fwd_data[p] = fifo_data_q[slot];
        end
      end
      if (!found && write_q && (wb_addr_q == look_add[p])) begin
        found       = 1'b1;
        fwd_data[p] = wb_data_q;
      end
      fwd_hit[p] = found;
    end
  end

  assign fwd1_hit  = fwd_hit[0];
  assign fwd2_hit  = fwd_hit[1];
  assign fwd3_hit  = fwd_hit[2];
  assign fwd4_hit  = fwd_hit[3];
  assign fwd1_data = fwd_data[0];
  assign fwd2_data = fwd_data[1];
  assign fwd3_data = fwd_data[2];
  assign fwd4_data = fwd_data[3];
`else
  logic unused_fwd;
  assign unused_fwd = ^{src1_add, src2_add, src3_add, dest_add};
  assign fwd1_hit  = 1'b0;
  assign fwd2_hit  = 1'b0;
  assign fwd3_hit  = 1'b0;
  assign fwd4_hit  = 1'b0;
  assign fwd1_data = 32'd0;
  assign fwd2_data = 32'd0;
  assign fwd3_data = 32'd0;
  assign fwd4_data = 32'd0;
`endif

  assign write              = write_q;
  assign write_back_address = wb_addr_q;
  assign data_write         = wb_data_q;
  assign stall              = (count_q >= 3'd3);
  assign overflow           = overflow_q;
  assign count              = count_q;

endmodule

// File: tb/tb_wb_write_buffer.sv
// Directed bench for wb_write_buffer: a per-cycle vector table followed by
// hand-written overflow-drain and pointer-wrap sequences.
module tb_wb_write_buffer;

`ifdef WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clock, reset_n, freeze;
  logic        ex_valid, mem_valid;
  logic [3:0]  ex_addr, mem_addr;
  logic [31:0] ex_data, mem_data;
  logic [3:0]  src1_add, src2_add, src3_add, dest_add;
  logic        fwd1_hit, fwd2_hit, fwd3_hit, fwd4_hit;
  logic [31:0] fwd1_data, fwd2_data, fwd3_data, fwd4_data;
  logic        write, stall, overflow;
  logic [3:0]  write_back_address;
  logic [31:0] data_write;
  logic [2:0]  count;

  wb_write_buffer dut (
    .clock(clock), .reset_n(reset_n),
    .ex_valid(ex_valid), .ex_addr(ex_addr), .ex_data(ex_data),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data),
    .freeze(freeze),
    .src1_add(src1_add), .src2_add(src2_add), .src3_add(src3_add), .dest_add(dest_add),
    .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
    .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
    .fwd3_hit(fwd3_hit), .fwd3_data(fwd3_data),
    .fwd4_hit(fwd4_hit), .fwd4_data(fwd4_data),
    .write(write), .write_back_address(write_back_address), .data_write(data_write),
    .stall(stall), .overflow(overflow), .count(count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst_n, frz, mem_v, ex_v;
    logic [3:0]  mem_a, ex_a, src;
    logic [31:0] mem_d, ex_d;
    logic [2:0]  e_cnt;
    logic        e_wr, e_stall, e_ovf, e_hit;
    logic [3:0]  e_wa;
    logic [31:0] e_wd, e_fd;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic [3:0]  wq_a[$];
  logic [31:0] wq_d[$];
  int          wq_c[$];

  function automatic void add(int rst, int frz, int mv, int ma, logic [31:0] md,
                              int ev, int ea, logic [31:0] ed, int s,
                              int cnt, int wr, int wa, logic [31:0] wd,
                              int stl, int ovf, int hit, logic [31:0] fd);
    vec_t v;
    v.rst_n = 1'(rst);  v.frz = 1'(frz);
    v.mem_v = 1'(mv);   v.mem_a = 4'(ma); v.mem_d = md;
    v.ex_v  = 1'(ev);   v.ex_a  = 4'(ea); v.ex_d  = ed;
    v.src   = 4'(s);
    v.e_cnt = 3'(cnt);  v.e_wr = 1'(wr); v.e_wa = 4'(wa); v.e_wd = wd;
    v.e_stall = 1'(stl); v.e_ovf = 1'(ovf);
    v.e_hit = 1'(hit) & FWD;
    v.e_fd  = FWD ? fd : 32'd0;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic frz, input logic mv, input logic [3:0] ma,
                       input logic [31:0] md, input logic ev, input logic [3:0] ea,
                       input logic [31:0] ed, input logic [3:0] s);
    reset_n = rst; freeze = frz;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    ex_valid = ev; ex_addr = ea; ex_data = ed;
    src1_add = s; src2_add = s; src3_add = s; dest_add = s;
  endtask

  // Advance one edge, sample 1 time unit later, log any write pulse
  task automatic tick();
    @(posedge clock);
    #1;
    if (write === 1'b1) begin
      wq_a.push_back(write_back_address);
      wq_d.push_back(data_write);
      wq_c.push_back(cyc);
    end
    cyc++;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 4'd0);

    //  rst frz mv ma md            ev ea ed        src cnt wr wa wd            st ov hit fd
    add(0, 0, 1, 3,  32'h111,      0, 0, 32'h0,    3,  0, 0, 0, 32'h0,        0, 0, 0, 32'h0);
    add(1, 0, 1, 3,  32'hDEAD0003, 0, 0, 32'h0,    3,  1, 0, 0, 32'h0,        0, 0, 1, 32'hDEAD0003);
    add(1, 0, 0, 0,  32'h0,        0, 0, 32'h0,    3,  0, 1, 3, 32'hDEAD0003, 0, 0, 1, 32'hDEAD0003);
    add(1, 0, 0, 0,  32'h0,        0, 0, 32'h0,    3,  0, 0, 3, 32'hDEAD0003, 0, 0, 0, 32'h0);
    add(1, 0, 1, 5,  32'h50,       1, 5, 32'h55,   5,  2, 0, 3, 32'hDEAD0003, 0, 0, 1, 32'h55);
    add(1, 0, 0, 0,  32'h0,        0, 0, 32'h0,    5,  1, 1, 5, 32'h50,       0, 0, 1, 32'h55);
    add(1, 0, 0, 0,  32'h0,        0, 0, 32'h0,    5,  0, 1, 5, 32'h55,       0, 0, 1, 32'h55);
    add(1, 0, 0, 0,  32'h0,        0, 0, 32'h0,    5,  0, 0, 5, 32'h55,       0, 0, 0, 32'h0);
    add(1, 0, 1, 15, 32'hF0,       1, 7, 32'h70,   15, 2, 0, 5, 32'h55,       0, 0, 1, 32'hF0);
    add(1, 1, 0, 0,  32'h0,        0, 0, 32'h0,    7,  2, 0, 5, 32'h55,       0, 0, 1, 32'h70);
    add(1, 1, 0, 0,  32'h0,        1, 15, 32'hF1,  15, 3, 0, 5, 32'h55,       1, 0, 1, 32'hF1);
    add(1, 1, 1, 2,  32'h20,       1, 4, 32'h40,   4,  4, 0, 5, 32'h55,       1, 1, 0, 32'h0);
    add(1, 0, 0, 0,  32'h0,        0, 0, 32'h0,    15, 3, 1, 15, 32'hF0,      1, 1, 1, 32'hF1);
    add(1, 0, 0, 0,  32'h0,        0, 0, 32'h0,    7,  2, 1, 7, 32'h70,       0, 1, 1, 32'h70);
    add(1, 0, 0, 0,  32'h0,        0, 0, 32'h0,    2,  1, 1, 15, 32'hF1,      0, 1, 1, 32'h20);
    add(1, 0, 0, 0,  32'h0,        0, 0, 32'h0,    0,  0, 1, 2, 32'h20,       0, 1, 0, 32'h0);
    add(1, 0, 0, 0,  32'h0,        0, 0, 32'h0,    0,  0, 0, 2, 32'h20,       0, 1, 0, 32'h0);
    add(0, 0, 0, 0,  32'h0,        1, 9, 32'h99,   9,  0, 0, 0, 32'h0,        0, 0, 0, 32'h0);
    add(1, 1, 1, 1,  32'h01,       1, 2, 32'h02,   1,  2, 0, 0, 32'h0,        0, 0, 1, 32'h01);
    add(1, 1, 1, 3,  32'h03,       1, 4, 32'h04,   3,  4, 0, 0, 32'h0,        1, 0, 1, 32'h03);
    add(1, 0, 1, 5,  32'h05,       1, 6, 32'h06,   6,  4, 1, 1, 32'h01,       1, 1, 0, 32'h0);
    add(0, 0, 1, 6,  32'h66,       0, 0, 32'h0,    5,  0, 0, 0, 32'h0,        0, 0, 0, 32'h0);
    add(1, 0, 0, 0,  32'h0,        0, 0, 32'h0,    5,  0, 0, 0, 32'h0,        0, 0, 0, 32'h0);
    add(1, 0, 0, 0,  32'h0,        0, 0, 32'h0,    5,  0, 0, 0, 32'h0,        0, 0, 0, 32'h0);

    foreach (vecs[k]) begin
      drive(vecs[k].rst_n, vecs[k].frz, vecs[k].mem_v, vecs[k].mem_a, vecs[k].mem_d,
            vecs[k].ex_v, vecs[k].ex_a, vecs[k].ex_d, vecs[k].src);
      tick();
      chk($sformatf("v%0d count", k), 32'(count), 32'(vecs[k].e_cnt));
      chk($sformatf("v%0d write", k), 32'(write), 32'(vecs[k].e_wr));
      chk($sformatf("v%0d wb_addr", k), 32'(write_back_address), 32'(vecs[k].e_wa));
      chk($sformatf("v%0d wb_data", k), data_write, vecs[k].e_wd);
      chk($sformatf("v%0d stall", k), 32'(stall), 32'(vecs[k].e_stall));
      chk($sformatf("v%0d overflow", k), 32'(overflow), 32'(vecs[k].e_ovf));
      chk($sformatf("v%0d fwd1_hit", k), 32'(fwd1_hit), 32'(vecs[k].e_hit));
      chk($sformatf("v%0d fwd1_data", k), fwd1_data, vecs[k].e_fd);
      chk($sformatf("v%0d fwd4_hit", k), 32'(fwd4_hit), 32'(vecs[k].e_hit));
      chk($sformatf("v%0d fwd4_data", k), fwd4_data, vecs[k].e_fd);
    end

    // Frozen dual requests fill the FIFO; the third pair is dropped
    wq_a.delete(); wq_d.delete(); wq_c.delete();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b1, 1'b1, 4'(2*c + 1), 32'h3100 + 32'(c), 1'b1, 4'(2*c + 2),
            32'h3200 + 32'(c), 4'd0);
      tick();
      chk($sformatf("ovf c%0d count", c), 32'(count), (c == 0) ? 32'd2 : 32'd4);
      chk($sformatf("ovf c%0d stall", c), 32'(stall), (c == 0) ? 32'd0 : 32'd1);
      chk($sformatf("ovf c%0d overflow", c), 32'(overflow), (c == 2) ? 32'd1 : 32'd0);
    end
    cyc = 0;
    wq_a.delete(); wq_d.delete(); wq_c.delete();
    drive(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 4'd0);
    for (int c = 0; c < 8; c++) tick();
    chk("ovf drain writes", 32'(wq_a.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < wq_a.size()) begin
        chk($sformatf("ovf drain %0d cycle", k), 32'(wq_c[k]), 32'(k));
        chk($sformatf("ovf drain %0d addr", k), 32'(wq_a[k]), 32'(k + 1));
        chk($sformatf("ovf drain %0d data", k), wq_d[k],
            ((k % 2) == 0) ? 32'h3100 + 32'(k / 2) : 32'h3200 + 32'(k / 2));
      end
    end
    chk("ovf drain sticky", 32'(overflow), 32'd1);

    // Ten single requests with periodic freeze: pointers wrap twice, nothing lost
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 4'd0);
    tick();
    wq_a.delete(); wq_d.delete(); wq_c.delete();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, ((i % 3) == 1), 1'b1, 4'(i), 32'hA000_0000 + 32'(i), 1'b0, 4'd0, 32'd0, 4'd0);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 4'd0);
    for (int i = 0; i < 10; i++) tick();
    chk("wrap writes", 32'(wq_a.size()), 32'd10);
    for (int k = 0; k < 10; k++) begin
      if (k < wq_a.size()) begin
        chk($sformatf("wrap %0d addr", k), 32'(wq_a[k]), 32'(k));
        chk($sformatf("wrap %0d data", k), wq_d[k], 32'hA000_0000 + 32'(k));
      end
    end
    chk("wrap count", 32'(count), 32'd0);
    chk("wrap overflow", 32'(overflow), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
